// File: rtl/exec_pkg.sv
// exec_pkg: constants shared by the execution sequencer and the ALU.
//   - ACC_W: accumulator / operand width
//   - opcode constants (the arithmetic and test codes double as ALU function codes)
//   - sequencer state encodings
//   - saturation limits used when EXEC_SATURATE_EN is defined
package exec_pkg;

  localparam int ACC_W = 11;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_CLRF = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_NOT  = 4'b1011;
  localparam logic [3:0] OP_TEQ  = 4'b1100;
  localparam logic [3:0] OP_TGT  = 4'b1101;
  localparam logic [3:0] OP_TLT  = 4'b1110;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WB    = 2'd2;

  localparam int SAT_MAX = 999;
  localparam int SAT_MIN = -999;

  // Ops that actually exercise the ALU (arithmetic and tests).
  function automatic logic uses_alu(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_NOT, OP_TEQ, OP_TGT, OP_TLT};
  endfunction

endpackage

// File: rtl/exec_saturate.sv
// exec_saturate: combinational clamp of an ADD/SUB/MUL result to [SAT_MIN, SAT_MAX].
// Only instantiated when EXEC_SATURATE_EN is defined.
// Ports:
//   value        in  raw ALU result
//   alu_overflow in  ALU overflow for this result
//   sign_acc     in  sign of the accumulator operand
//   sign_src     in  sign of the source operand
//   op           in  opcode being retired
//   clamped      out value after clamping
//   clamp        out high when clamping changed the result
module exec_saturate
  import exec_pkg::*;
(
  input  logic [ACC_W-1:0] value,
  input  logic             alu_overflow,
  input  logic             sign_acc,
  input  logic             sign_src,
  input  logic [3:0]       op,
  output logic [ACC_W-1:0] clamped,
  output logic             clamp
);

  logic neg;

  always_comb begin
    clamped = value;
    clamp   = 1'b0;
    neg     = 1'b0;
    if (op inside {OP_ADD, OP_SUB, OP_MUL}) begin
      if (alu_overflow) begin
        // The wrapped value has the wrong sign, so the true sign comes from the
        // operands: ADD overflows only with equal signs, acc - src keeps the sign
        // of acc, and a product's sign is the XOR of its factors.
        case (op)
          OP_MUL:  neg = sign_acc ^ sign_src;
          default: neg = sign_acc;
        endcase
        clamp   = 1'b1;
        clamped = neg ? ACC_W'(SAT_MIN) : ACC_W'(SAT_MAX);
      end else if ($signed(value) > SAT_MAX) begin
        clamp   = 1'b1;
        clamped = ACC_W'(SAT_MAX);
      end else if ($signed(value) < SAT_MIN) begin
        clamp   = 1'b1;
        clamped = ACC_W'(SAT_MIN);
      end
    end
  end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: single-issue execution sequencer driving a combinational ALU.
// Holds the signed accumulator, the +/- condition flags and a sticky overflow flag.
// Optional feature: define EXEC_SATURATE_EN to clamp ADD/SUB/MUL results to +/-999.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   instr_valid/ready/op/src       instruction handshake from fetch
//   resp_valid                     one-cycle retire pulse
//   acc, cond_plus, cond_minus,
//   ovf_sticky                     architectural state
//   alu_in0, alu_in1, alu_funct    registered ALU operands / function
//   alu_out, alu_overflow,
//   alu_gr, alu_le, alu_eq         ALU result and compare flags
//
// state | meaning
// IDLE  | ready; accept latches op/src
// ISSUE | register ALU operands and function
// WB    | ALU settled; capture result, pulse resp_valid on exit
module exec_unit
  import exec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [ACC_W-1:0] instr_src,
  output logic             resp_valid,
  output logic [ACC_W-1:0] acc,
  output logic             cond_plus,
  output logic             cond_minus,
  output logic             ovf_sticky,
  output logic [ACC_W-1:0] alu_in0,
  output logic [ACC_W-1:0] alu_in1,
  output logic [3:0]       alu_funct,
  input  logic [ACC_W-1:0] alu_out,
  input  logic             alu_overflow,
  input  logic             alu_gr,
  input  logic             alu_le,
  input  logic             alu_eq
);

  logic [1:0]       state;
  logic [3:0]       op_q;
  logic [ACC_W-1:0] src_q;
  logic [ACC_W-1:0] wb_val;
  logic             sat_flag;

  assign instr_ready = (state == IDLE);

`ifdef EXEC_SATURATE_EN
  exec_saturate u_saturate (
    .value        (alu_out),
    .alu_overflow (alu_overflow),
    .sign_acc     (acc[ACC_W-1]),
    .sign_src     (src_q[ACC_W-1]),
    .op           (op_q),
    .clamped      (wb_val),
    .clamp        (sat_flag)
  );
`else
  assign wb_val   = alu_out;
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_NOP;
      src_q      <= '0;
      acc        <= '0;
      cond_plus  <= 1'b0;
      cond_minus <= 1'b0;
      ovf_sticky <= 1'b0;
      resp_valid <= 1'b0;
      alu_in0    <= '0;
      alu_in1    <= '0;
      alu_funct  <= 4'b0000;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q  <= instr_op;
            src_q <= instr_src;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WB;
          if (uses_alu(op_q)) begin
            alu_funct <= op_q;
            // The ALU subtracts in1 - in0, so swap to get acc - src.
            if (op_q == OP_SUB) begin
              alu_in0 <= src_q;
              alu_in1 <= acc;
            end else begin
              alu_in0 <= acc;
              alu_in1 <= src_q;
            end
          end else begin
            alu_funct <= 4'b0000;
            alu_in0   <= '0;
            alu_in1   <= '0;
          end
        end
        WB: begin
          state      <= IDLE;
          resp_valid <= 1'b1;
          case (op_q)
            OP_ADD, OP_SUB, OP_MUL, OP_NOT: begin
              acc        <= wb_val;
              ovf_sticky <= ovf_sticky | alu_overflow | sat_flag;
            end
            OP_MOV: acc <= src_q;
            OP_CLRF: begin
              cond_plus  <= 1'b0;
              cond_minus <= 1'b0;
              ovf_sticky <= 1'b0;
            end
            OP_TEQ: begin
              cond_plus  <= alu_eq;
              cond_minus <= ~alu_eq;
            end
            OP_TGT: begin
              cond_plus  <= alu_gr;
              cond_minus <= ~alu_gr;
            end
            OP_TLT: begin
              cond_plus  <= alu_le;
              cond_minus <= ~alu_le;
            end
            default: ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: self-checking bench for exec_unit, including a behavioural ALU.
module tb_exec_unit;
  import exec_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic [3:0]       instr_op = 4'b0000;
  logic [ACC_W-1:0] instr_src = '0;
  logic             resp_valid;
  logic [ACC_W-1:0] acc;
  logic             cond_plus, cond_minus, ovf_sticky;
  logic [ACC_W-1:0] alu_in0, alu_in1;
  logic [3:0]       alu_funct;
  logic [ACC_W-1:0] alu_out;
  logic             alu_overflow, alu_gr, alu_le, alu_eq;

  always #5 clk = ~clk;

  exec_unit dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_src(instr_src),
    .resp_valid(resp_valid), .acc(acc),
    .cond_plus(cond_plus), .cond_minus(cond_minus), .ovf_sticky(ovf_sticky),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_funct(alu_funct),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .alu_gr(alu_gr), .alu_le(alu_le), .alu_eq(alu_eq)
  );

  // Behavioural combinational ALU: difference is in1 - in0, le means in0 < in1.
  int alu_a, alu_b, alu_r;
  always_comb begin
    alu_a = $signed(alu_in0);
    alu_b = $signed(alu_in1);
    alu_r = 0;
    case (alu_funct)
      4'b1000: alu_r = alu_a + alu_b;
      4'b1001: alu_r = alu_b - alu_a;
      4'b1010: alu_r = alu_a * alu_b;
      4'b1011: alu_r = (alu_a == 0) ? 127 : 0;
      default: alu_r = 0;
    endcase
    alu_out      = alu_r[ACC_W-1:0];
    alu_overflow = (alu_r > 1023) || (alu_r < -1024);
    alu_gr       = alu_a > alu_b;
    alu_le       = alu_a < alu_b;
    alu_eq       = alu_a == alu_b;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state from plain integer arithmetic.
  int m_acc = 0;
  bit m_plus = 0, m_minus = 0, m_ovf = 0;

  function automatic int wrap11(input int v);
    int m;
    m = (v + 1024) % 2048;
    if (m < 0) m += 2048;
    return m - 1024;
  endfunction

  task automatic model_exec(input logic [3:0] op, input logic [ACC_W-1:0] src);
    int s, r;
    s = $signed(src);
    r = 0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL: begin
        if (op == OP_ADD) r = m_acc + s;
        else if (op == OP_SUB) r = m_acc - s;
        else r = m_acc * s;
`ifdef EXEC_SATURATE_EN
        if (r > 999) begin m_acc = 999; m_ovf = 1; end
        else if (r < -999) begin m_acc = -999; m_ovf = 1; end
        else m_acc = r;
`else
        if (r > 1023 || r < -1024) m_ovf = 1;
        m_acc = wrap11(r);
`endif
      end
      OP_NOT:  m_acc = (m_acc == 0) ? 127 : 0;
      OP_MOV:  m_acc = s;
      OP_CLRF: begin m_plus = 0; m_minus = 0; m_ovf = 0; end
      OP_TEQ:  begin m_plus = (m_acc == s); m_minus = !m_plus; end
      OP_TGT:  begin m_plus = (m_acc > s);  m_minus = !m_plus; end
      OP_TLT:  begin m_plus = (m_acc < s);  m_minus = !m_plus; end
      default: ;
    endcase
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_acc"}, $signed(acc), m_acc);
    chk({tag, "_plus"}, int'(cond_plus), int'(m_plus));
    chk({tag, "_minus"}, int'(cond_minus), int'(m_minus));
    chk({tag, "_ovf"}, int'(ovf_sticky), int'(m_ovf));
  endtask

  // Issue one instruction from a negedge and check timing, ALU operands and retire.
  task automatic do_instr(input logic [3:0] op, input logic [ACC_W-1:0] src);
    int t, acc_before, s;
    bit alu_op;
    t = 0;
    while (!instr_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!instr_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    acc_before  = m_acc;
    s           = $signed(src);
    alu_op      = (op >= 4'b1000) && (op <= 4'b1110);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_src   = src;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr_op    = 4'($urandom);
    instr_src   = 11'($urandom);
    chk("resp_early", int'(resp_valid), 0);
    chk("busy_ready", int'(instr_ready), 0);
    @(negedge clk);
    chk("resp_early2", int'(resp_valid), 0);
    chk("alu_funct", int'(alu_funct), alu_op ? int'(op) : 0);
    if (alu_op) begin
      chk("alu_in0", $signed(alu_in0), (op == OP_SUB) ? s : acc_before);
      chk("alu_in1", $signed(alu_in1), (op == OP_SUB) ? acc_before : s);
    end
    @(negedge clk);
    chk("resp_retire", int'(resp_valid), 1);
    model_exec(op, src);
    check_state("retire");
    @(negedge clk);
    chk("resp_width", int'(resp_valid), 0);
  endtask

  typedef struct {
    logic [3:0] op;
    int         src;
    int         exp_acc;
    bit         exp_plus;
    bit         exp_minus;
    bit         exp_ovf;
  } vec_t;

`ifdef EXEC_SATURATE_EN
  localparam int MUL_EXP = 999;
  localparam int ADDOVF_EXP = 999;
`else
  localparam int MUL_EXP = -848;
  localparam int ADDOVF_EXP = -1024;
`endif

  vec_t tbl[$];
  logic [3:0] bb_op[4];
  logic [ACC_W-1:0] bb_src[4];
  int bb_edges[$];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl.push_back('{OP_MOV,    5,    5,         0, 0, 0});
    tbl.push_back('{OP_ADD,    7,    12,        0, 0, 0});
    tbl.push_back('{OP_SUB,    20,   -8,        0, 0, 0});
    tbl.push_back('{OP_MOV,    40,   40,        0, 0, 0});
    tbl.push_back('{OP_MUL,    30,   MUL_EXP,   0, 0, 1});
    tbl.push_back('{OP_CLRF,   0,    MUL_EXP,   0, 0, 0});
    tbl.push_back('{OP_MOV,    3,    3,         0, 0, 0});
    tbl.push_back('{OP_TGT,    2,    3,         1, 0, 0});
    tbl.push_back('{OP_TLT,    2,    3,         0, 1, 0});
    tbl.push_back('{OP_TEQ,    3,    3,         1, 0, 0});
    tbl.push_back('{OP_MOV,    0,    0,         1, 0, 0});
    tbl.push_back('{OP_NOT,    0,    127,       1, 0, 0});
    tbl.push_back('{OP_NOT,    5,    0,         1, 0, 0});
    tbl.push_back('{4'b0111,   9,    0,         1, 0, 0});
    tbl.push_back('{OP_MOV,    1023, 1023,      1, 0, 0});
    tbl.push_back('{OP_ADD,    1,    ADDOVF_EXP, 1, 0, 1});
    tbl.push_back('{4'b1111,   77,   ADDOVF_EXP, 1, 0, 1});
    tbl.push_back('{OP_CLRF,   0,    ADDOVF_EXP, 0, 0, 0});

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_acc", $signed(acc), 0);
    chk("rst_resp", int'(resp_valid), 0);
    chk("rst_ready", int'(instr_ready), 1);
    chk("rst_flags", int'({cond_plus, cond_minus, ovf_sticky}), 0);
    chk("rst_alu", int'({alu_in0, alu_in1, alu_funct}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    foreach (tbl[i]) begin
      do_instr(tbl[i].op, 11'(tbl[i].src));
      chk("tbl_acc", $signed(acc), tbl[i].exp_acc);
      chk("tbl_plus", int'(cond_plus), int'(tbl[i].exp_plus));
      chk("tbl_minus", int'(cond_minus), int'(tbl[i].exp_minus));
      chk("tbl_ovf", int'(ovf_sticky), int'(tbl[i].exp_ovf));
    end

    // Back-to-back with instr_valid held high
    bb_op  = '{OP_MOV, OP_ADD, OP_SUB, OP_MUL};
    bb_src = '{11'd10, 11'd5, 11'd3, 11'd2};
    begin
      int idx, ret, resp_cnt;
      bit will;
      idx = 0; ret = 0; resp_cnt = 0;
      for (int c = 0; c < 16; c++) begin
        if (idx < 4) begin
          instr_valid = 1'b1;
          instr_op    = bb_op[idx];
          instr_src   = bb_src[idx];
        end else begin
          instr_valid = 1'b0;
        end
        will = instr_ready && instr_valid;
        @(posedge clk);
        if (will) begin
          bb_edges.push_back(c);
          idx++;
        end
        @(negedge clk);
        if (resp_valid) begin
          resp_cnt++;
          if (ret < 4) begin
            model_exec(bb_op[ret], bb_src[ret]);
            ret++;
            check_state("b2b");
          end
        end
      end
      instr_valid = 1'b0;
      chk("b2b_accepts", bb_edges.size(), 4);
      chk("b2b_resp_cnt", resp_cnt, 4);
      for (int k = 0; k < 4; k++)
        chk("b2b_edge", (k < bb_edges.size()) ? bb_edges[k] : -1, 3 * k);
      chk("b2b_final_acc", $signed(acc), 24);
    end

    // Randomized instructions against the model
    repeat (60) begin
      logic [3:0] rop;
      logic [ACC_W-1:0] rsrc;
      rop  = 4'($urandom);
      rsrc = ($urandom_range(1, 0) == 1) ? 11'($urandom_range(40, 0)) : 11'($urandom);
      do_instr(rop, rsrc);
    end

    // Reset during ISSUE aborts the instruction
    do_instr(OP_MOV, 11'd50);
    chk("pre_abort_acc", $signed(acc), 50);
    instr_valid = 1'b1;
    instr_op    = OP_ADD;
    instr_src   = 11'd100;
    @(posedge clk);
    @(negedge clk);
    instr_op    = OP_MOV;
    instr_src   = 11'd77;
    rst_n       = 1'b0;
    #1;
    m_acc = 0; m_plus = 0; m_minus = 0; m_ovf = 0;
    check_state("abort");
    chk("abort_resp", int'(resp_valid), 0);
    chk("abort_ready", int'(instr_ready), 1);
    chk("abort_alu", int'({alu_in0, alu_in1, alu_funct}), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_resp", int'(resp_valid), 0);
      chk("abort_no_accept", $signed(acc), 0);
    end
    instr_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(instr_ready), 1);
    chk("post_rst_resp", int'(resp_valid), 0);
    do_instr(OP_ADD, 11'd100);
    chk("post_rst_acc", $signed(acc), 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
